// File: rtl/round_robin_dispatcher.sv
// Round-robin task dispatcher feeding n_blocks non-pipelined compute blocks in strict order.
// Tracks per-block busy state and flags completion pulses that do not match an outstanding task.
module round_robin_dispatcher #(
  parameter int unsigned width    = 16,
  parameter int unsigned n_blocks = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              up_vld,
  input  logic [width-1:0]                  up_data,
  output logic                              up_rdy,
  output logic [n_blocks-1:0]               blk_start,
  output logic [n_blocks*width-1:0]         blk_data,
  input  logic [n_blocks-1:0]               blk_done,
  output logic [$clog2(n_blocks+1)-1:0]     inflight,
  output logic                              idle,
  output logic                              err
);

  localparam int unsigned ptr_w = $clog2(n_blocks);
  localparam int unsigned cnt_w = $clog2(n_blocks + 1);

  logic [ptr_w-1:0]          ptr_q, ptr_d;
  logic [n_blocks-1:0]       busy_q, busy_d;
  logic [n_blocks-1:0]       start_q, start_d;
  logic [n_blocks*width-1:0] data_q, data_d;
  logic                      err_q, err_d;

  logic                      hs;
  logic [n_blocks-1:0]       sel;
  logic [n_blocks-1:0]       done_ok;
  logic [n_blocks-1:0]       done_bad;
  logic [cnt_w-1:0]          cnt;

  // Head-of-line: only the pointed-to block may accept, which keeps the collector's order.
  assign up_rdy = !rst && !busy_q[ptr_q];
  assign hs     = up_vld && up_rdy;

  // A done is only legitimate for a busy block that is not being started this cycle.
  assign done_ok  = blk_done & busy_q & ~start_q;
  assign done_bad = blk_done & (~busy_q | start_q);

  always_comb begin
    sel = '0;
    sel[ptr_q] = 1'b1;
  end

  always_comb begin
    busy_d  = busy_q & ~done_ok;
    start_d = '0;
    ptr_d   = ptr_q;
    data_d  = data_q;
    err_d   = err_q | (|done_bad);
    if (hs) begin
      busy_d  = busy_d | sel;
      start_d = sel;
      if (ptr_q == ptr_w'(n_blocks - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + ptr_w'(1);
      end
      for (int unsigned i = 0; i < n_blocks; i++) begin
        if (ptr_q == ptr_w'(i)) begin
          data_d[i*width +: width] = up_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      busy_q  <= '0;
      start_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < n_blocks; i++) begin
      cnt = cnt + cnt_w'(busy_q[i]);
    end
  end

  assign inflight  = cnt;
  assign idle      = (busy_q == '0) && (start_q == '0);
  assign blk_start = start_q;
  assign blk_data  = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_round_robin_dispatcher.sv
// Scoreboard bench for round_robin_dispatcher: expected starts are queued by the driver and
// popped by a monitor whenever any blk_start bit is seen; status outputs are checked inline.
module tb_round_robin_dispatcher;

  localparam int W = 16;
  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               up_vld;
  logic [W-1:0]       up_data;
  logic               up_rdy;
  logic [N-1:0]       blk_start;
  logic [N*W-1:0]     blk_data;
  logic [N-1:0]       blk_done;
  logic [2:0]         inflight;
  logic               idle;
  logic               err;

  int checks = 0;
  int errors = 0;

  int         exp_blk[$];
  logic [W-1:0] exp_dat[$];

  round_robin_dispatcher #(.width(W), .n_blocks(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (up_vld),
    .up_data   (up_data),
    .up_rdy    (up_rdy),
    .blk_start (blk_start),
    .blk_data  (blk_data),
    .blk_done  (blk_done),
    .inflight  (inflight),
    .idle      (idle),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] data_of(input int k);
    return blk_data[k*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a task that must be accepted this cycle, and queue the start it should cause.
  task automatic send(input int blk, input logic [W-1:0] d);
    up_vld  = 1'b1;
    up_data = d;
    #0;
    chk("up_rdy_before_send", {31'b0, up_rdy}, 32'd1);
    exp_blk.push_back(blk);
    exp_dat.push_back(d);
    tick();
    up_vld = 1'b0;
  endtask

  task automatic done(input logic [N-1:0] mask);
    blk_done = mask;
    tick();
    blk_done = '0;
  endtask

  // Monitor: every start pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (blk_start !== '0) begin
        if (exp_blk.size() == 0) begin
          chk("unexpected_start", {28'b0, blk_start}, 32'd0);
        end else begin
          int b;
          logic [W-1:0] d;
          b = exp_blk.pop_front();
          d = exp_dat.pop_front();
          chk("start_onehot", {28'b0, blk_start}, 32'd1 << b);
          chk("start_data", {16'b0, data_of(b)}, {16'b0, d});
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    up_vld   = 1'b1;
    up_data  = 16'h1234;
    blk_done = 4'b0011;
    #1;
    tick();
    chk("rdy_in_reset", {31'b0, up_rdy}, 32'd0);
    tick();
    rst      = 1'b0;
    up_vld   = 1'b0;
    blk_done = '0;
    #0;
    chk("rst_inflight", {29'b0, inflight}, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdy", {31'b0, up_rdy}, 32'd1);
    chk("rst_data", blk_data[31:0], 32'd0);

    // Four back-to-back tasks land on blocks 0..3.
    for (int k = 0; k < 4; k++) send(k, 16'hA0 + 16'(k));
    up_vld  = 1'b1;
    up_data = 16'hA4;
    #0;
    chk("full_inflight", {29'b0, inflight}, 32'd4);
    chk("full_rdy", {31'b0, up_rdy}, 32'd0);
    chk("full_idle", {31'b0, idle}, 32'd0);
    for (int k = 0; k < 4; k++) chk("full_data", {16'b0, data_of(k)}, 32'hA0 + 32'(k));

    // Valid held with ready low for three cycles: nothing changes.
    up_data = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_rdy", {31'b0, up_rdy}, 32'd0);
    end
    up_vld = 1'b0;
    for (int k = 0; k < 4; k++) chk("stall_data", {16'b0, data_of(k)}, 32'hA0 + 32'(k));

    // Block 2 frees first but pointer sits on busy block 0.
    done(4'b0100);
    chk("d2_inflight", {29'b0, inflight}, 32'd3);
    chk("d2_rdy", {31'b0, up_rdy}, 32'd0);
    blk_done = 4'b0001;
    #0;
    chk("d0_same_cycle_rdy", {31'b0, up_rdy}, 32'd0);
    tick();
    blk_done = '0;
    chk("d0_rdy", {31'b0, up_rdy}, 32'd1);
    send(0, 16'hB0);
    chk("b0_inflight", {29'b0, inflight}, 32'd3);
    chk("b0_rdy_ptr1_busy", {31'b0, up_rdy}, 32'd0);

    // Move the pointer to block 3 with blocks 0,1,2 busy.
    done(4'b0010);
    send(1, 16'hB1);
    send(2, 16'hB2);
    done(4'b1000);
    chk("pre_sim_inflight", {29'b0, inflight}, 32'd3);

    // Done on block 1 concurrent with handshake to block 3.
    blk_done = 4'b0010;
    send(3, 16'hB3);
    blk_done = '0;
    chk("sim_inflight", {29'b0, inflight}, 32'd3);
    chk("sim_err", {31'b0, err}, 32'd0);
    chk("sim_rdy", {31'b0, up_rdy}, 32'd0);

    // Spurious done on idle block 2 sets a sticky error.
    done(4'b0100);
    chk("pre_err_inflight", {29'b0, inflight}, 32'd2);
    chk("pre_err_err", {31'b0, err}, 32'd0);
    done(4'b0100);
    chk("spur_err", {31'b0, err}, 32'd1);
    chk("spur_inflight", {29'b0, inflight}, 32'd2);
    tick();
    tick();
    chk("spur_err_sticky", {31'b0, err}, 32'd1);

    // Get to three in flight, then reset mid-operation.
    done(4'b0001);
    send(0, 16'hD0);
    send(1, 16'hD1);
    chk("pre_rst_inflight", {29'b0, inflight}, 32'd3);
    rst      = 1'b1;
    up_vld   = 1'b1;
    up_data  = 16'hEEEE;
    blk_done = 4'b0100;
    #0;
    chk("rst_mid_rdy", {31'b0, up_rdy}, 32'd0);
    tick();
    rst      = 1'b0;
    up_vld   = 1'b0;
    blk_done = '0;
    #0;
    chk("rst2_inflight", {29'b0, inflight}, 32'd0);
    chk("rst2_idle", {31'b0, idle}, 32'd1);
    chk("rst2_start", {28'b0, blk_start}, 32'd0);
    chk("rst2_err", {31'b0, err}, 32'd0);
    chk("rst2_data", blk_data[63:32], 32'd0);
    send(0, 16'hC0);
    chk("c0_inflight", {29'b0, inflight}, 32'd1);

    // Done for an abandoned task is a protocol error.
    done(4'b0010);
    chk("abandoned_err", {31'b0, err}, 32'd1);
    chk("abandoned_inflight", {29'b0, inflight}, 32'd1);

    tick();
    tick();
    chk("queue_drained", exp_blk.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
